comparator_search_controller: RTL
=================================

# comparator_search_controller

Sequential counterpart to the 4-bit `Comparitor`. The testbench sweeps `ComparisonInput` blindly; this block instead drives `ComparisonInput` and consumes `G`/`E`/`L` to binary-search the unknown `ComparisonReference`. It reports the matched value and the probe count. It sits beside the comparator in the Lab 3 datapath and replaces the free-running stimulus counter.

## Interface
- `Width`, 4: comparator operand width.
- `ProbeWidth`, 3: probe counter width; must hold `Width+1`.
- `Clk  in  1`: rising-edge clock.
- `ResetN  in  1`: asynchronous, active-low reset.
- `Start  in  1`: begin a search; sampled only in IDLE.
- `G  in  1`: comparator output, reference > guess.
- `E  in  1`: comparator output, reference == guess.
- `L  in  1`: comparator output, reference < guess.
- `Guess  out  Width`: registered; drives `ComparisonInput`.
- `Busy  out  1`: high in SETTLE and SAMPLE.
- `Done  out  1`: one-cycle pulse at search end.
- `Found  out  1`: last search matched; held until next Start.
- `Result  out  Width`: matched value; valid when `Found`=1; held.
- `Probes  out  ProbeWidth`: comparisons made in last or current search.
- `Error  out  1`: `G`/`E`/`L` not one-hot during a sample; held until next Start.

## Operation
- States:
  - IDLE: waits for `Start`.
  - SETTLE: one cycle for `Guess` to propagate through the comparator.
  - SAMPLE: evaluates `G`/`E`/`L`.
  - DONE: one cycle with `Done`=1, then back to IDLE.
- Internal registers `Low` and `High` are `Width+1` bits, unsigned. `Guess` = `(Low+High)>>1`, truncated to `Width`.
- IDLE & `Start`:
  - `Low`←0, `High`←2^Width−1, `Guess`←(2^Width−1)>>1.
  - `Probes`←0; `Found`, `Error`, `Result` cleared.
  - Next state SETTLE.
- SETTLE→SAMPLE unconditionally.
- SAMPLE, with `Probes` incremented on every sample:
  - `E` only: `Found`←1, `Result`←`Guess`; →DONE.
  - `G` only, `Guess`==2^Width−1: not found; →DONE.
  - `G` only, otherwise: `Low`←`Guess`+1.
  - `L` only, `Guess`==0: not found; →DONE.
  - `L` only, otherwise: `High`←`Guess`−1.
  - After a `G` or `L` update: if new `Low`>`High`, →DONE not found. Else `Guess`←new midpoint, →SETTLE.
  - Not one-hot (zero, or two or more asserted): `Error`←1, `Found`←0; →DONE.
- `Start` outside IDLE is ignored; no restart, no queuing.
- The search cannot exceed `Width+1` probes. Five probes for `Width`=4.

## Timing
- Reset values of all outputs:
  - State IDLE.
  - `Guess`=0, `Busy`=0, `Done`=0, `Found`=0, `Result`=0, `Probes`=0, `Error`=0.
  - `Low`=0, `High`=0.
- Reset asserted mid-search: immediate return to reset values, with no `Done` pulse.
- Each probe costs 2 cycles (SETTLE, SAMPLE). `G`/`E`/`L` are sampled at the rising edge that ends SAMPLE.
- For a search of N probes, `Done`=1 during the cycle after edge 2N following the edge that sampled `Start`. Equivalently, `Done` is visible 2N+1 edges after `Start` is sampled.
- `Found`, `Result`, `Error`, `Probes` update at the same edge that enters DONE, and hold through IDLE.
- `Guess` changes only at the edge entering SETTLE, so it is stable for both SETTLE and SAMPLE.
- `Start` held high through DONE is re-sampled in IDLE and triggers a new search. Back-to-back searches are legal.

## Test plan
- Reference 7, pulse `Start` -> `Guess`=7; `Done` 3 edges later with `Found`=1, `Result`=7, `Probes`=1.
- Reference 0 -> `Guess` sequence 7,3,1,0; `Found`=1, `Result`=0, `Probes`=4; `Done` 9 edges after `Start`.
- Reference 15 -> `Guess` sequence 7,11,13,14,15; `Found`=1, `Result`=15, `Probes`=5; `Done` 11 edges after `Start`.
- Stub comparator forcing `G`=1 always -> `Guess` sequence 7,11,13,14,15; `Found`=0, `Error`=0, `Probes`=5.
- Stub forcing `G`=`E`=1 on the first probe -> `Error`=1, `Found`=0, `Probes`=1, `Done` 3 edges after `Start`.
- Reference 10, assert `ResetN` low during the second SETTLE -> all outputs 0 immediately, no `Done`. After release, `Start` completes normally: `Guess` sequence 7,11,9,10, `Result`=10, `Probes`=4. A `Start` pulse while `Busy`=1 is ignored.

Source files
------------

// File: rtl/comparator_search_controller.sv
// rtl/comparator_search_controller.sv - binary search of a 4-bit comparator reference via G/E/L feedback
module comparator_search_controller #(
  parameter int Width      = 4,
  parameter int ProbeWidth = 3
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic                  G,
  input  logic                  E,
  input  logic                  L,
  output logic [Width-1:0]      Guess,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Found,
  output logic [Width-1:0]      Result,
  output logic [ProbeWidth-1:0] Probes,
  output logic                  Error
);

  localparam int BW = Width + 1;
  localparam logic [BW-1:0] MaxVal = {1'b0, {Width{1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         low_q, low_d;
  logic [BW-1:0]         high_q, high_d;
  logic [Width-1:0]      guess_q, guess_d;
  logic                  found_q, found_d;
  logic [Width-1:0]      result_q, result_d;
  logic [ProbeWidth-1:0] probes_q, probes_d;
  logic                  error_q, error_d;

  logic [BW-1:0] low_n, high_n, guess_ext, mid_sum;
  logic          step;

  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    high_d    = high_q;
    guess_d   = guess_q;
    found_d   = found_q;
    result_d  = result_q;
    probes_d  = probes_q;
    error_d   = error_q;
    low_n     = low_q;
    high_n    = high_q;
    guess_ext = {1'b0, guess_q};
    mid_sum   = '0;
    step      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          low_d    = '0;
          high_d   = MaxVal;
          guess_d  = Width'(MaxVal >> 1);
          probes_d = '0;
          found_d  = 1'b0;
          error_d  = 1'b0;
          result_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: state_d = SAMPLE;
      SAMPLE: begin
        probes_d = probes_q + ProbeWidth'(1);
        state_d  = DONE;
        case ({G, E, L})
          3'b010: begin
            found_d  = 1'b1;
            result_d = guess_q;
          end
          3'b100: begin
            if (guess_q != '1) begin
              low_n = guess_ext + BW'(1);
              step  = 1'b1;
            end
          end
          3'b001: begin
            if (guess_q != '0) begin
              high_n = guess_ext - BW'(1);
              step   = 1'b1;
            end
          end
          default: begin
            error_d = 1'b1;
            found_d = 1'b0;
          end
        endcase
        // An empty interval after narrowing means the reference is not reachable.
        if (step) begin
          low_d  = low_n;
          high_d = high_n;
          if (low_n <= high_n) begin
            mid_sum = low_n + high_n;
            guess_d = Width'(mid_sum >> 1);
            state_d = SETTLE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      low_q    <= '0;
      high_q   <= '0;
      guess_q  <= '0;
      found_q  <= 1'b0;
      result_q <= '0;
      probes_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      low_q    <= low_d;
      high_q   <= high_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      result_q <= result_d;
      probes_q <= probes_d;
      error_q  <= error_d;
    end
  end

  assign Guess  = guess_q;
  assign Busy   = (state_q == SETTLE) || (state_q == SAMPLE);
  assign Done   = (state_q == DONE);
  assign Found  = found_q;
  assign Result = result_q;
  assign Probes = probes_q;
  assign Error  = error_q;

endmodule
